// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction controller.
// Provides the one-hot direction encoding, its type, and a helper that
// returns the opposite of a direction (left<->right, up<->down).
package snake_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_NONE  = 4'b0000;
  localparam dir_t DIR_LEFT  = 4'b0001;
  localparam dir_t DIR_RIGHT = 4'b0010;
  localparam dir_t DIR_UP    = 4'b0100;
  localparam dir_t DIR_DOWN  = 4'b1000;

  // Opposite of a single direction; anything else (incl. stopped) maps to stopped.
  function automatic dir_t dir_opposite(dir_t dir);
    dir_t opp;
    case (dir)
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_UP:    opp = DIR_DOWN;
      DIR_DOWN:  opp = DIR_UP;
      default:   opp = DIR_NONE;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, debounce counter and
// rising-edge press detector.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   raw   - raw button level, asynchronous to clk
//   press - one-cycle pulse on each debounced rising edge (release gives nothing)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q, sync_q;
  logic            stable_q, stable_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronised level has disagreed with
  // the stable level; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: conditions the four direction buttons, filters
// duplicate/reversing turns and queues accepted turns so that one is applied
// per game move tick.
// Ports:
//   clk           - system clock
//   reset         - synchronous, active-high reset
//   l, r, u, d    - raw direction buttons, asynchronous to clk
//   move_tick     - one-cycle pulse, snake advances this cycle
//   direction     - current one-hot direction (0000 = stopped)
//   moving        - registered (direction != 0000)
//   pending_count - number of queued turns
//   turn_dropped  - one-cycle pulse when a press is rejected
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter bit          ALLOW_REVERSE   = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 l,
  input  logic                                 r,
  input  logic                                 u,
  input  logic                                 d,
  input  logic                                 move_tick,
  output logic [3:0]                           direction,
  output logic                                 moving,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     pending_count,
  output logic                                 turn_dropped
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CntW-1:0] FullCount = CntW'(QUEUE_DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(QUEUE_DEPTH - 1);

  // Button conditioning; bit order matches the one-hot direction encoding.
  logic [3:0] press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk   (clk),
    .reset (reset),
    .raw   (l),
    .press (press[0])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .raw   (r),
    .press (press[1])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
    .clk   (clk),
    .reset (reset),
    .raw   (u),
    .press (press[2])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk   (clk),
    .reset (reset),
    .raw   (d),
    .press (press[3])
  );

  // State
  dir_t            fifo_q [QUEUE_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  dir_t            dir_q, dir_d;
  logic            moving_q;
  logic            dropped_q;

  // Decision signals
  dir_t            cand;
  dir_t            ref_dir;
  logic [PtrW-1:0] tail_ptr;
  logic            full;
  logic            reject;
  logic            push;
  logic            pop;
  logic            drop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + 1'b1;
  endfunction

  // Only the highest-priority simultaneous press is considered (l > r > u > d).
  always_comb begin
    cand = DIR_NONE;
    if (press[0]) begin
      cand = DIR_LEFT;
    end else if (press[1]) begin
      cand = DIR_RIGHT;
    end else if (press[2]) begin
      cand = DIR_UP;
    end else if (press[3]) begin
      cand = DIR_DOWN;
    end
  end

  // New turns are judged against the last queued turn, or the live direction
  // when nothing is queued, so a double-tap is checked against its predecessor.
  always_comb begin
    tail_ptr = (wr_ptr_q == '0) ? PtrLast : wr_ptr_q - 1'b1;
    ref_dir  = (count_q != '0) ? fifo_q[tail_ptr] : dir_q;
    full     = (count_q == FullCount);
    pop      = move_tick && (count_q != '0);
    reject   = (cand == ref_dir) ||
               (!ALLOW_REVERSE && (cand == dir_opposite(ref_dir))) ||
               (full && !move_tick);
    push     = (cand != DIR_NONE) && !reject;
    drop     = (cand != DIR_NONE) && reject;
  end

  always_comb begin
    dir_d    = dir_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      dir_d    = fifo_q[rd_ptr_q];
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dir_q     <= DIR_NONE;
      moving_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      moving_q  <= (dir_d != DIR_NONE);
      dropped_q <= drop;
    end
  end

  // Entry storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_q[wr_ptr_q] <= cand;
    end
  end

  assign direction     = dir_q;
  assign moving        = moving_q;
  assign pending_count = count_q;
  assign turn_dropped  = dropped_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: two instances (reversal disallowed / allowed)
// share the same buttons and are checked every cycle against a queue-based
// model, with directed scenarios pinning known values.
module tb_snake_dir_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned QD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;        // bit0 l, bit1 r, bit2 u, bit3 d
  logic       move_tick;

  logic [3:0] dut_dir   [2];
  logic       dut_mov   [2];
  logic [1:0] dut_cnt   [2];
  logic       dut_drop  [2];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .QUEUE_DEPTH     (QD),
    .ALLOW_REVERSE   (1'b0)
  ) dut0 (
    .clk           (clk),
    .reset         (reset),
    .l             (btn[0]),
    .r             (btn[1]),
    .u             (btn[2]),
    .d             (btn[3]),
    .move_tick     (move_tick),
    .direction     (dut_dir[0]),
    .moving        (dut_mov[0]),
    .pending_count (dut_cnt[0]),
    .turn_dropped  (dut_drop[0])
  );

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .QUEUE_DEPTH     (QD),
    .ALLOW_REVERSE   (1'b1)
  ) dut1 (
    .clk           (clk),
    .reset         (reset),
    .l             (btn[0]),
    .r             (btn[1]),
    .u             (btn[2]),
    .d             (btn[3]),
    .move_tick     (move_tick),
    .direction     (dut_dir[1]),
    .moving        (dut_mov[1]),
    .pending_count (dut_cnt[1]),
    .turn_dropped  (dut_drop[1])
  );

  // ---------------- behavioural model ----------------
  // Buttons: the level seen two edges late; "run" = consecutive disagreeing
  // edges, a flip once the disagreement has lasted DC edges.
  bit m_s1[4], m_s2[4], m_stab[4], m_prev[4];
  int m_run[4];
  // Turns: plain shift queue per instance.
  int m_q[2][QD];
  int m_cnt[2];
  int m_dir[2];
  bit m_mov[2];
  bit m_drop[2];

  function automatic int opposite(int x);
    if (x == 1) return 2;
    if (x == 2) return 1;
    if (x == 4) return 8;
    if (x == 8) return 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_dir[k] = 0; m_mov[k] = 0; m_drop[k] = 0;
      end
    end else begin
      int cand;
      cand = 0;
      for (int b = 3; b >= 0; b--) if (m_stab[b] && !m_prev[b]) cand = 1 << b;
      for (int k = 0; k < 2; k++) begin
        int  refd;
        bit  do_push, do_pop;
        refd    = (m_cnt[k] > 0) ? m_q[k][m_cnt[k]-1] : m_dir[k];
        do_pop  = move_tick && (m_cnt[k] > 0);
        do_push = 0;
        m_drop[k] = 0;
        if (cand != 0) begin
          if (cand == refd || (k == 0 && cand == opposite(refd)) ||
              (m_cnt[k] == QD && !move_tick)) m_drop[k] = 1;
          else do_push = 1;
        end
        if (do_pop) begin
          m_dir[k] = m_q[k][0];
          for (int i = 0; i < QD - 1; i++) m_q[k][i] = m_q[k][i+1];
          m_cnt[k]--;
        end
        if (do_push) begin
          m_q[k][m_cnt[k]] = cand;
          m_cnt[k]++;
        end
        m_mov[k] = (m_dir[k] != 0);
      end
      for (int b = 0; b < 4; b++) begin
        m_prev[b] = m_stab[b];
        if (m_s2[b] != m_stab[b]) begin
          if (m_run[b] + 1 == DC) begin
            m_stab[b] = ~m_stab[b];
            m_run[b]  = 0;
          end else begin
            m_run[b]++;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = btn[b];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model dir[%0d]", k), int'(dut_dir[k]), m_dir[k]);
        check($sformatf("model moving[%0d]", k), int'(dut_mov[k]), int'(m_mov[k]));
        check($sformatf("model count[%0d]", k), int'(dut_cnt[k]), m_cnt[k]);
        check($sformatf("model dropped[%0d]", k), int'(dut_drop[k]), int'(m_drop[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Raise buttons and return just after edge DC+3 (the write/drop edge);
  // optionally pulse move_tick on that same edge.
  task automatic press(input logic [3:0] mask, input bit tick_on_write);
    btn = btn | mask;
    repeat (DC + 2) @(negedge clk);
    if (tick_on_write) move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  task automatic release_btn(input logic [3:0] mask);
    btn = btn & ~mask;
    repeat (DC + 4) @(negedge clk);
  endtask

  task automatic tick();
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn       = 4'b0;
    move_tick = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset dir", int'(dut_dir[0]), 0);
    check("reset moving", int'(dut_mov[0]), 0);
    check("reset count", int'(dut_cnt[0]), 0);
    check("reset dropped", int'(dut_drop[0]), 0);

    // 1: hold u; write lands on edge 7, tick on edge 10 applies it.
    reset = 1'b0;
    btn[2] = 1'b1;
    repeat (6) @(negedge clk);
    check("t1 count after edge 6", int'(dut_cnt[0]), 0);
    @(negedge clk);
    check("t1 count after edge 7", int'(dut_cnt[0]), 1);
    repeat (2) @(negedge clk);
    tick();
    check("t1 dir", int'(dut_dir[0]), 4);
    check("t1 moving", int'(dut_mov[0]), 1);
    check("t1 count", int'(dut_cnt[0]), 0);
    release_btn(4'b0100);

    // 2: a 3-cycle glitch never gets through.
    do_reset();
    btn[2] = 1'b1;
    repeat (3) @(negedge clk);
    btn[2] = 1'b0;
    repeat (12) @(negedge clk);
    check("t2 count", int'(dut_cnt[0]), 0);
    check("t2 dir", int'(dut_dir[0]), 0);

    // 3: reversal down from up.
    press(4'b0100, 1'b0);
    release_btn(4'b0100);
    tick();
    press(4'b1000, 1'b0);
    check("t3 drop ar0", int'(dut_drop[0]), 1);
    check("t3 count ar0", int'(dut_cnt[0]), 0);
    check("t3 drop ar1", int'(dut_drop[1]), 0);
    check("t3 count ar1", int'(dut_cnt[1]), 1);
    @(negedge clk);
    check("t3 drop pulse ends", int'(dut_drop[0]), 0);
    release_btn(4'b1000);
    tick();
    check("t3 dir ar1", int'(dut_dir[1]), 8);
    check("t3 dir ar0", int'(dut_dir[0]), 4);

    // 4: l, r, l, d against direction up.
    do_reset();
    press(4'b0100, 1'b0);
    release_btn(4'b0100);
    tick();
    press(4'b0001, 1'b0);
    check("t4 l accepted", int'(dut_cnt[0]), 1);
    release_btn(4'b0001);
    press(4'b0010, 1'b0);
    check("t4 r dropped", int'(dut_drop[0]), 1);
    release_btn(4'b0010);
    press(4'b0001, 1'b0);
    check("t4 l dup dropped", int'(dut_drop[0]), 1);
    release_btn(4'b0001);
    press(4'b1000, 1'b0);
    check("t4 d accepted", int'(dut_cnt[0]), 2);
    release_btn(4'b1000);
    tick();
    check("t4 tick1 dir", int'(dut_dir[0]), 1);
    tick();
    check("t4 tick2 dir", int'(dut_dir[0]), 8);

    // 5: full queue; press without tick dropped, with tick accepted.
    press(4'b0001, 1'b0);
    release_btn(4'b0001);
    press(4'b0100, 1'b0);
    release_btn(4'b0100);
    check("t5 full", int'(dut_cnt[0]), 2);
    press(4'b0010, 1'b0);
    check("t5 full drop", int'(dut_drop[0]), 1);
    check("t5 full count", int'(dut_cnt[0]), 2);
    release_btn(4'b0010);
    press(4'b0010, 1'b1);
    check("t5 tick push drop", int'(dut_drop[0]), 0);
    check("t5 tick push count", int'(dut_cnt[0]), 2);
    check("t5 tick push dir", int'(dut_dir[0]), 1);
    release_btn(4'b0010);

    // 6: simultaneous l+u, then reset with a full queue.
    do_reset();
    press(4'b0101, 1'b0);
    check("t6 l+u count", int'(dut_cnt[0]), 1);
    check("t6 l+u no drop", int'(dut_drop[0]), 0);
    release_btn(4'b0101);
    tick();
    check("t6 l+u dir", int'(dut_dir[0]), 1);
    press(4'b0100, 1'b0);
    release_btn(4'b0100);
    press(4'b0010, 1'b0);  // reverse of tail u? no: right after up is fine
    release_btn(4'b0010);
    check("t6 full", int'(dut_cnt[0]), 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 reset dir", int'(dut_dir[0]), 0);
    check("t6 reset count", int'(dut_cnt[0]), 0);

    // Random phase: slow-toggling buttons with glitches, ticks, rare resets.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      move_tick = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    reset     = 1'b0;
    move_tick = 1'b0;
    btn       = 4'b0;
    repeat (DC + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Parametrised successor to the snake game's direction latch. It debounces and edge-detects the four direction buttons and rejects reversal and duplicate turns. Accepted turns go into a small FIFO. One turn is applied per game move tick, so quick double-taps (e.g. up then left within one move) are kept and applied in order rather than overwritten. It sits between the board button pins and the snake movement/game-state logic.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronised button must differ from its stable value before the stable value flips; legal range >= 1.
QUEUE_DEPTH, 2, number of pending turns buffered; legal range >= 1, power of two not required.
ALLOW_REVERSE, 0, 1 accepts a turn opposite to the reference direction; 0 drops it.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
l  in  1  raw left button, asynchronous to clk
r  in  1  raw right button, asynchronous to clk
u  in  1  raw up button, asynchronous to clk
d  in  1  raw down button, asynchronous to clk
move_tick  in  1  one-cycle pulse; snake advances one cell this cycle
direction  out  4  current direction, one-hot: 0001 left, 0010 right, 0100 up, 1000 down, 0000 stopped
moving  out  1  1 when direction != 0000
pending_count  out  $clog2(QUEUE_DEPTH+1)  turns in FIFO
turn_dropped  out  1  one-cycle pulse when a press is rejected

Behaviour:
- Reset, sampled on a clk edge with reset=1, clears the following: direction=0000, moving=0, pending_count=0, turn_dropped=0, FIFO pointers, synchronisers, debounce counters, and the stable and previous-stable button values.
- Reset mid-debounce or with a non-empty FIFO discards everything. A button still held after reset is released produces a press once its debounce completes again.
- Per button: 2-flop synchroniser, then debounce.
  - The counter increments on each edge where the synchronised value != stable.
  - The counter clears to 0 on any edge where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, stable flips and the counter clears.
- Press pulse = registered rising edge of stable. Holding a button yields exactly one press. Release yields nothing.
- Latency: raw button rises before edge 1 and is held. The FIFO write or drop happens at edge DEBOUNCE_CYCLES+3. pending_count (or turn_dropped) is visible after that edge.
- Multiple presses in the same cycle: only the highest priority is considered (left > right > up > down). The others are ignored and do not raise turn_dropped.
- Reference direction = FIFO tail entry if pending_count > 0, else direction. Both are pre-edge values.
- A candidate is dropped (turn_dropped=1 for one cycle, no write) if any of the following holds:
  - it equals the reference direction;
  - ALLOW_REVERSE=0 and it is the opposite of the reference (left<->right, up<->down);
  - the FIFO is full and move_tick=0.
- From reference 0000, every direction is accepted.
- move_tick with pending_count > 0: direction <= FIFO head and the head is popped, both on the same edge. With pending_count = 0, direction holds.
- Simultaneous push and move_tick: the pop and push happen on the same edge.
  - pending_count is unchanged.
  - A full FIFO accepts the push.
  - The reference is still evaluated on pre-edge state.
- The push/pop pointers wrap modulo QUEUE_DEPTH. pending_count saturates at neither end; overflow and underflow are prevented by the rules above.
- moving is a registered copy of (direction != 0000) and is updated on the same edge as direction.
- There is no path back to 0000 except reset.

Decomposition:
- snake_pkg: DIR_NONE / DIR_LEFT / DIR_RIGHT / DIR_UP / DIR_DOWN 4-bit constants, typedef dir_t, and function dir_opposite(dir_t).
- Sub-module btn_debounce (synchroniser + counter + stable + press pulse), parameter DEBOUNCE_CYCLES, instantiated 4x.
- The FIFO and acceptance logic stay in snake_dir_ctrl.

Test Plan:
1. DEBOUNCE_CYCLES=4. Reset, then hold u from edge 1. pending_count goes 0->1 at edge 7. move_tick at edge 10 gives direction=0100 and moving=1 after edge 10; pending_count returns to 0.
2. u glitch of 3 cycles then release, DEBOUNCE_CYCLES=4 -> no FIFO write, no turn_dropped, direction stays 0000.
3. direction=0100, press d, ALLOW_REVERSE=0 -> turn_dropped pulses once, pending_count stays 0. Repeat with ALLOW_REVERSE=1 -> accepted; next tick gives direction=1000.
4. direction=0100, QUEUE_DEPTH=2. Press l, then r, then l, with no ticks in between:
   - l is accepted.
   - r is dropped (opposite of tail l).
   - l is dropped (duplicate).
   - Then press d: accepted, count=2.
   - Ticks apply 0001 then 1000.
5. FIFO full (count=2). A valid press without a tick is dropped. The same press coinciding with move_tick is accepted; count stays 2.
6. l and u pressed in the same cycle -> only 0001 is enqueued, no turn_dropped. Reset asserted with count=2 -> next cycle direction=0000, pending_count=0.
